// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues in-order fetch requests, tracks them in a small FIFO and
// drops responses made stale by decode redirects. Define FETCH_SEQUENCER_FAST_REDIRECT_EN to issue the redirect target in the squash cycle.
module fetch_sequencer #(
   parameter int unsigned              p_addr_bits     = 32,
   parameter int unsigned              p_inst_bits     = 32,
   parameter logic [p_addr_bits-1:0]   p_rst_addr      = '0,
   parameter int unsigned              p_max_in_flight = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [p_addr_bits-1:0] mem_req_addr,
   input  logic                   mem_resp_val,
   output logic                   mem_resp_rdy,
   input  logic [p_inst_bits-1:0] mem_resp_data,
   output logic                   d_val,
   input  logic                   d_rdy,
   output logic [p_addr_bits-1:0] d_pc,
   output logic [p_inst_bits-1:0] d_inst,
   input  logic                   squash,
   input  logic [p_addr_bits-1:0] branch_target
);

   localparam int unsigned ptr_w = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;
   localparam int unsigned cnt_w = $clog2(p_max_in_flight + 1);
   localparam logic [cnt_w-1:0]       max_cnt   = cnt_w'(p_max_in_flight);
   localparam logic [ptr_w-1:0]       last_ptr  = ptr_w'(p_max_in_flight - 1);
   localparam logic [p_addr_bits-1:0] inst_step = p_addr_bits'(4);

   logic [p_addr_bits-1:0]     pc_q, pc_d;
   logic [cnt_w-1:0]           occ_q, occ_d;
   logic [ptr_w-1:0]           head_q, head_d;
   logic [ptr_w-1:0]           tail_q, tail_d;
   logic [p_max_in_flight-1:0] stale_q, stale_d;
   logic [p_addr_bits-1:0]     addr_q [p_max_in_flight];

   logic nonempty;
   logic head_stale;
   logic free_slot;
   logic push;
   logic pop;

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == last_ptr) ? '0 : p + ptr_w'(1);
   endfunction

   assign nonempty   = (occ_q != '0);
   assign head_stale = stale_q[head_q];
   assign free_slot  = (occ_q < max_cnt);

   // Request channel; rst_n gating keeps mem_req_val low while reset is held.
`ifdef FETCH_SEQUENCER_FAST_REDIRECT_EN
   assign mem_req_val  = rst_n & free_slot;
   assign mem_req_addr = squash ? branch_target : pc_q;
`else
   assign mem_req_val  = rst_n & free_slot & ~squash;
   assign mem_req_addr = pc_q;
`endif

   assign d_val        = mem_resp_val & nonempty & ~head_stale;
   assign d_pc         = addr_q[head_q];
   assign d_inst       = mem_resp_data;
   assign mem_resp_rdy = nonempty & (head_stale | d_rdy | squash);

   assign push = mem_req_val & mem_req_rdy;
   assign pop  = mem_resp_val & mem_resp_rdy;

   // Next-state: FIFO pointers/occupancy, stale marking and fetch PC.
   always_comb begin
      pc_d    = pc_q;
      occ_d   = occ_q;
      head_d  = head_q;
      tail_d  = tail_q;
      stale_d = stale_q;

      if (pop) begin
         head_d = ptr_inc(head_q);
      end
      // Marking every slot is safe: the popped and free slots are rewritten before reuse.
      if (squash) begin
         stale_d = '1;
      end
      if (push) begin
         stale_d[tail_q] = 1'b0;
         tail_d          = ptr_inc(tail_q);
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + cnt_w'(1);
         2'b01:   occ_d = occ_q - cnt_w'(1);
         default: occ_d = occ_q;
      endcase

      if (squash) begin
         pc_d = push ? branch_target + inst_step : branch_target;
      end else if (push) begin
         pc_d = pc_q + inst_step;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= p_rst_addr;
         occ_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         stale_q <= '0;
      end else begin
         pc_q    <= pc_d;
         occ_q   <= occ_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         stale_q <= stale_d;
      end
   end

   // Address payload needs no reset; validity is carried by occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= mem_req_addr;
      end
   end

   resp_needs_outstanding_req : assert property (
      @(posedge clk) disable iff (!rst_n) !(mem_resp_val && (occ_q == '0)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: ideal in-order memory model, decode-side scoreboard of expected PCs.
module tb_fetch_sequencer;

   localparam logic [31:0] rst_addr = 32'h200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req_val, mem_req_rdy;
   logic [31:0] mem_req_addr;
   logic        mem_resp_val, mem_resp_rdy;
   logic [31:0] mem_resp_data;
   logic        d_val, d_rdy;
   logic [31:0] d_pc, d_inst;
   logic        squash;
   logic [31:0] branch_target;
   logic        resp_en;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] mem_q [$];
   int          mem_cnt = 0;
   logic [31:0] mem_head = '0;
   logic [31:0] req_log [$];
   logic [31:0] dq_pc [$];
   logic [31:0] dq_inst [$];
   int          n_req = 0;
   int          n_resp = 0;
   logic [31:0] exp_q [$];
   int          deliv_rd = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   fetch_sequencer #(
      .p_addr_bits     (32),
      .p_inst_bits     (32),
      .p_rst_addr      (rst_addr),
      .p_max_in_flight (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req_val   (mem_req_val),
      .mem_req_rdy   (mem_req_rdy),
      .mem_req_addr  (mem_req_addr),
      .mem_resp_val  (mem_resp_val),
      .mem_resp_rdy  (mem_resp_rdy),
      .mem_resp_data (mem_resp_data),
      .d_val         (d_val),
      .d_rdy         (d_rdy),
      .d_pc          (d_pc),
      .d_inst        (d_inst),
      .squash        (squash),
      .branch_target (branch_target)
   );

   assign mem_resp_val  = resp_en && (mem_cnt > 0);
   assign mem_resp_data = inst_of(mem_head);

   // Memory model (response one cycle after request, in order) and delivery monitor.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q.delete();
         n_req  = 0;
         n_resp = 0;
         mem_cnt  <= 0;
         mem_head <= '0;
      end else begin
         if (mem_resp_val && mem_resp_rdy) begin
            void'(mem_q.pop_front());
            n_resp++;
         end
         if (mem_req_val && mem_req_rdy) begin
            mem_q.push_back(mem_req_addr);
            req_log.push_back(mem_req_addr);
            n_req++;
         end
         if (d_val && d_rdy && !squash) begin
            dq_pc.push_back(d_pc);
            dq_inst.push_back(d_inst);
         end
         mem_cnt  <= mem_q.size();
         mem_head <= (mem_q.size() > 0) ? mem_q[0] : 32'h0;
      end
   end

   task automatic check_deliveries();
      logic [31:0] e;
      for (; deliv_rd < dq_pc.size(); deliv_rd++) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deliver_extra got pc=%h inst=%h, none expected", dq_pc[deliv_rd], dq_inst[deliv_rd]);
         end else begin
            e = exp_q.pop_front();
            if (dq_pc[deliv_rd] !== e || dq_inst[deliv_rd] !== inst_of(e)) begin
               errors++;
               $display("FAIL deliver got pc=%h inst=%h want pc=%h inst=%h",
                        dq_pc[deliv_rd], dq_inst[deliv_rd], e, inst_of(e));
            end
         end
      end
   endtask

   task automatic expect_from(input logic [31:0] start);
      logic [31:0] a;
      check_deliveries();
      exp_q.delete();
      a = start;
      for (int i = 0; i < 64; i++) begin
         exp_q.push_back(a);
         a = a + 32'd4;
      end
   endtask

   task automatic wait_deliv(input int n, input int budget, output bit ok);
      int target;
      target = dq_pc.size() + n;
      for (int i = 0; i < budget && dq_pc.size() < target; i++) @(negedge clk);
      ok = (dq_pc.size() >= target);
   endtask

   task automatic wait_reqs(input int target, input int budget, output bit ok);
      for (int i = 0; i < budget && req_log.size() < target; i++) @(negedge clk);
      ok = (req_log.size() >= target);
   endtask

   task automatic test_reset();
      mem_req_rdy = 1'b1; d_rdy = 1'b1; squash = 1'b0; branch_target = '0; resp_en = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL reset_req_val got %b want 0", mem_req_val); end
      checks++; if (d_val !== 1'b0) begin errors++; $display("FAIL reset_d_val got %b want 0", d_val); end
      checks++; if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy got %b want 0", mem_resp_rdy); end
      expect_from(rst_addr);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (mem_req_val !== 1'b1) begin errors++; $display("FAIL first_req_val got %b want 1", mem_req_val); end
      checks++; if (mem_req_addr !== rst_addr) begin errors++; $display("FAIL first_req_addr got %h want %h", mem_req_addr, rst_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] want [3];
      int base;
      bit ok;
      want[0] = 32'h200; want[1] = 32'h204; want[2] = 32'h208;
      base = req_log.size() - ((mem_req_val && mem_req_rdy) ? 0 : 0);
      base = 0;
      wait_deliv(3, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got %0d deliveries want 3", dq_pc.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (req_log.size() <= base + i) begin
            errors++; $display("FAIL stream_req%0d got none want %h", i, want[i]);
         end else if (req_log[base + i] !== want[i]) begin
            errors++; $display("FAIL stream_req%0d got %h want %h", i, req_log[base + i], want[i]);
         end
      end
      check_deliveries();
   endtask

   task automatic test_backpressure();
      bit ok;
      @(negedge clk);
      d_rdy = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      checks++; if (n_req - n_resp != 2) begin errors++; $display("FAIL bp_outstanding got %0d want 2", n_req - n_resp); end
      checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL bp_req_val got %b want 0", mem_req_val); end
      checks++; if (d_val !== 1'b1) begin errors++; $display("FAIL bp_d_val got %b want 1", d_val); end
      d_rdy = 1'b1;
      wait_deliv(4, 30, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_resume_timeout got %0d deliveries", dq_pc.size()); end
      check_deliveries();
   endtask

   task automatic test_squash();
      int base;
      int first;
      bit ok;
      @(negedge clk);
      base = req_log.size();
      d_rdy = 1'b0; squash = 1'b1; branch_target = 32'h100;
      expect_from(32'h100);
      @(negedge clk);
      squash = 1'b0;
      wait_reqs(base + 2, 20, ok);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (!ok) begin
         errors++; $display("FAIL sq_setup_reqs got %0d want 2", req_log.size() - base);
      end else if (req_log[base] !== 32'h100 || req_log[base + 1] !== 32'h104) begin
         errors++; $display("FAIL sq_setup_reqs got %h,%h want 00000100,00000104", req_log[base], req_log[base + 1]);
      end
      checks++; if (n_req - n_resp != 2) begin errors++; $display("FAIL sq_outstanding got %0d want 2", n_req - n_resp); end
      checks++; if (d_pc !== 32'h100) begin errors++; $display("FAIL sq_head_pc got %h want 00000100", d_pc); end
      @(negedge clk);
      squash = 1'b1; branch_target = 32'h400;
      expect_from(32'h400);
      #1;
      checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL sq_full_req_val got %b want 0", mem_req_val); end
      checks++; if (mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL sq_resp_rdy got %b want 1", mem_resp_rdy); end
      @(negedge clk);
      squash = 1'b0; d_rdy = 1'b1;
      #1;
      checks++; if (!(mem_resp_val === 1'b1 && d_val === 1'b0)) begin
         errors++; $display("FAIL sq_stale_drop got resp_val=%b d_val=%b want 1,0", mem_resp_val, d_val); end
      checks++; if (!(mem_req_val === 1'b1 && mem_req_addr === 32'h400)) begin
         errors++; $display("FAIL sq_redirect_req got val=%b addr=%h want 1,00000400", mem_req_val, mem_req_addr); end
      first = dq_pc.size();
      wait_deliv(1, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sq_next_timeout got none want 00000400"); end
      else if (dq_pc[first] !== 32'h400) begin errors++; $display("FAIL sq_next_pc got %h want 00000400", dq_pc[first]); end
      check_deliveries();
   endtask

   task automatic test_redirect_timing();
      int first;
      bit ok;
      @(negedge clk);
      mem_req_rdy = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checks++; if (n_req != n_resp) begin errors++; $display("FAIL rt_drain got %0d outstanding want 0", n_req - n_resp); end
      @(negedge clk);
      squash = 1'b1; branch_target = 32'h600; mem_req_rdy = 1'b1;
      expect_from(32'h600);
      #1;
`ifdef FETCH_SEQUENCER_FAST_REDIRECT_EN
      checks++; if (!(mem_req_val === 1'b1 && mem_req_addr === 32'h600)) begin
         errors++; $display("FAIL rt_squash_req got val=%b addr=%h want 1,00000600", mem_req_val, mem_req_addr); end
`else
      checks++; if (mem_req_val !== 1'b0) begin
         errors++; $display("FAIL rt_squash_req got val=%b want 0", mem_req_val); end
`endif
      @(negedge clk);
      squash = 1'b0;
      #1;
`ifdef FETCH_SEQUENCER_FAST_REDIRECT_EN
      checks++; if (!(mem_req_val === 1'b1 && mem_req_addr === 32'h604)) begin
         errors++; $display("FAIL rt_after_req got val=%b addr=%h want 1,00000604", mem_req_val, mem_req_addr); end
`else
      checks++; if (!(mem_req_val === 1'b1 && mem_req_addr === 32'h600)) begin
         errors++; $display("FAIL rt_after_req got val=%b addr=%h want 1,00000600", mem_req_val, mem_req_addr); end
`endif
      first = dq_pc.size();
      wait_deliv(2, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rt_next_timeout got none want 00000600"); end
      else if (dq_pc[first] !== 32'h600) begin errors++; $display("FAIL rt_next_pc got %h want 00000600", dq_pc[first]); end
      check_deliveries();
   endtask

   task automatic test_back_to_back();
      int first;
      bit ok;
      @(negedge clk);
      squash = 1'b1; branch_target = 32'h400;
      expect_from(32'h400);
      @(negedge clk);
      branch_target = 32'h800;
      expect_from(32'h800);
      @(negedge clk);
      squash = 1'b0;
      first = dq_pc.size();
      wait_deliv(1, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_timeout got none want 00000800"); end
      else if (dq_pc[first] !== 32'h800) begin errors++; $display("FAIL b2b_next_pc got %h want 00000800", dq_pc[first]); end
      check_deliveries();
   endtask

   task automatic test_wrap();
      int base;
      bit ok;
      @(negedge clk);
      base = req_log.size();
      squash = 1'b1; branch_target = 32'hFFFF_FFFC;
      expect_from(32'hFFFF_FFFC);
      @(negedge clk);
      squash = 1'b0;
      wait_reqs(base + 2, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_req0 got none want fffffffc"); end
      else if (req_log[base] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0 got %h want fffffffc", req_log[base]); end
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_req1 got none want 00000000"); end
      else if (req_log[base + 1] !== 32'h0) begin errors++; $display("FAIL wrap_req1 got %h want 00000000", req_log[base + 1]); end
      wait_deliv(2, 20, ok);
      check_deliveries();
   endtask

   task automatic test_reset_mid();
      int base;
      int first;
      bit ok;
      @(negedge clk);
      d_rdy = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checks++; if (n_req - n_resp != 2) begin errors++; $display("FAIL rm_outstanding got %0d want 2", n_req - n_resp); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL rm_req_val got %b want 0", mem_req_val); end
      checks++; if (d_val !== 1'b0) begin errors++; $display("FAIL rm_d_val got %b want 0", d_val); end
      checks++; if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL rm_resp_rdy got %b want 0", mem_resp_rdy); end
      expect_from(rst_addr);
      d_rdy = 1'b1;
      repeat (2) @(negedge clk);
      base = req_log.size();
      first = dq_pc.size();
      rst_n = 1'b1;
      #1;
      checks++; if (!(mem_req_val === 1'b1 && mem_req_addr === rst_addr)) begin
         errors++; $display("FAIL rm_restart_req got val=%b addr=%h want 1,%h", mem_req_val, mem_req_addr, rst_addr); end
      wait_deliv(1, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rm_next_timeout got none want %h", rst_addr); end
      else if (dq_pc[first] !== rst_addr) begin errors++; $display("FAIL rm_next_pc got %h want %h", dq_pc[first], rst_addr); end
      checks++;
      if (req_log.size() <= base) begin errors++; $display("FAIL rm_first_req got none want %h", rst_addr); end
      else if (req_log[base] !== rst_addr) begin errors++; $display("FAIL rm_first_req got %h want %h", req_log[base], rst_addr); end
      check_deliveries();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_squash();
      test_redirect_timing();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      repeat (2) @(negedge clk);
      check_deliveries();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got no completion within 100000 time units");
      $fatal(1);
   end

endmodule
